// File: rtl/ppc_pkg.sv
// ppc_pkg: shared definitions for the PowerPC-subset core.
//   GPR_WIDTH  - general-purpose register data width (bits)
//   GPR_COUNT  - number of general-purpose registers
//   GPR_AWIDTH - register index width, log2(GPR_COUNT)
// Bit numbering is big-endian: bit 0 is the MSB.
package ppc_pkg;

  localparam int GPR_WIDTH  = 64;
  localparam int GPR_COUNT  = 32;
  localparam int GPR_AWIDTH = 5;

  typedef logic [0:GPR_AWIDTH-1] gpr_addr_t;
  typedef logic [0:GPR_WIDTH-1]  gpr_data_t;

endpackage

// File: rtl/gpr_regs.sv
// gpr_regs: 32 x 64-bit general-purpose register file, 2 read / 2 write ports.
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous, active-high; clears storage and read data
//   readEnN/readAddrN    read port N request; readDataN registered, 1-cycle latency,
//                        holds its value while readEnN is low
//   writeEnN/writeAddrN/ write port N; lane 0 is the older instruction, lane 1 the
//   writeDataN           younger, so lane 1 wins on an address collision
// Reads see the pre-edge contents (no write-to-read bypass); r0 is an ordinary register.
module gpr_regs
  import ppc_pkg::*;
#(
  parameter int WIDTH  = GPR_WIDTH,
  parameter int COUNT  = GPR_COUNT,
  parameter int AWIDTH = GPR_AWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readEn0,
  input  logic [0:AWIDTH-1] readAddr0,
  output logic [0:WIDTH-1]  readData0,
  input  logic              readEn1,
  input  logic [0:AWIDTH-1] readAddr1,
  output logic [0:WIDTH-1]  readData1,
  input  logic              writeEn0,
  input  logic [0:AWIDTH-1] writeAddr0,
  input  logic [0:WIDTH-1]  writeData0,
  input  logic              writeEn1,
  input  logic [0:AWIDTH-1] writeAddr1,
  input  logic [0:WIDTH-1]  writeData1
);

  logic [0:WIDTH-1] regs [0:COUNT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COUNT; i++) begin
        regs[i] <= '0;
      end
      readData0 <= '0;
      readData1 <= '0;
    end else begin
      // Non-blocking reads sample the array before this edge's writes land,
      // which gives read-old-value on a same-cycle read/write collision.
      if (readEn0) readData0 <= regs[readAddr0];
      if (readEn1) readData1 <= regs[readAddr1];
      // Lane 1 is assigned last so the younger instruction wins a collision.
      if (writeEn0) regs[writeAddr0] <= writeData0;
      if (writeEn1) regs[writeAddr1] <= writeData1;
    end
  end

endmodule

// File: tb/tb_gpr_regs.sv
module tb_gpr_regs;
  import ppc_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      readEn0, readEn1, writeEn0, writeEn1;
  gpr_addr_t readAddr0, readAddr1, writeAddr0, writeAddr1;
  gpr_data_t readData0, readData1, writeData0, writeData1;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    string     tag;
    gpr_data_t data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  gpr_regs dut (
    .clk       (clk),
    .reset     (reset),
    .readEn0   (readEn0),
    .readAddr0 (readAddr0),
    .readData0 (readData0),
    .readEn1   (readEn1),
    .readAddr1 (readAddr1),
    .readData1 (readData1),
    .writeEn0  (writeEn0),
    .writeAddr0(writeAddr0),
    .writeData0(writeData0),
    .writeEn1  (writeEn1),
    .writeAddr1(writeAddr1),
    .writeData1(writeData1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input gpr_data_t obs, input gpr_data_t exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect0(input string tag, input gpr_data_t d);
    q0.push_back('{tag, d});
  endtask

  task automatic expect1(input string tag, input gpr_data_t d);
    q1.push_back('{tag, d});
  endtask

  task automatic idle();
    readEn0 = 1'b0; readEn1 = 1'b0; writeEn0 = 1'b0; writeEn1 = 1'b0;
    readAddr0 = '0; readAddr1 = '0; writeAddr0 = '0; writeAddr1 = '0;
    writeData0 = '0; writeData1 = '0;
  endtask

  // One clock: inputs were set away from the edge; sample 1 time unit after it,
  // pop the scoreboard for each port that was enabled, then return to idle.
  task automatic tick();
    exp_t e;
    logic s0, s1;
    s0 = readEn0;
    s1 = readEn1;
    @(posedge clk);
    #1;
    if (s0) begin
      if (q0.size() == 0) begin
        nCompared++; nMismatched++;
        $error("FAIL q0_empty: observed no entry expected an entry");
      end else begin
        e = q0.pop_front();
        check(e.tag, readData0, e.data);
      end
    end
    if (s1) begin
      if (q1.size() == 0) begin
        nCompared++; nMismatched++;
        $error("FAIL q1_empty: observed no entry expected an entry");
      end else begin
        e = q1.pop_front();
        check(e.tag, readData1, e.data);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_rd0", readData0, '0);
    check("rst_rd1", readData1, '0);

    // Reset contents on both ports
    readEn0 = 1; readAddr0 = 5'd0;  expect0("rst_r0_p0", '0);
    readEn1 = 1; readAddr1 = 5'd31; expect1("rst_r31_p1", '0);
    tick();
    readEn0 = 1; readAddr0 = 5'd31; expect0("rst_r31_p0", '0);
    readEn1 = 1; readAddr1 = 5'd0;  expect1("rst_r0_p1", '0);
    tick();

    // Basic write then read
    writeEn0 = 1; writeAddr0 = 5'd5; writeData0 = 64'h0123456789ABCDEF;
    tick();
    readEn0 = 1; readAddr0 = 5'd5; expect0("basic_r5", 64'h0123456789ABCDEF);
    readEn1 = 1; readAddr1 = 5'd6; expect1("basic_r6", '0);
    tick();

    // Same-address dual write: younger lane wins
    writeEn0 = 1; writeAddr0 = 5'd7; writeData0 = 64'h11;
    writeEn1 = 1; writeAddr1 = 5'd7; writeData1 = 64'h22;
    tick();
    readEn0 = 1; readAddr0 = 5'd7; expect0("dual_same_p0", 64'h22);
    readEn1 = 1; readAddr1 = 5'd7; expect1("dual_same_p1", 64'h22);
    tick();

    // Different-address dual write
    writeEn0 = 1; writeAddr0 = 5'd1; writeData0 = 64'hAAAA;
    writeEn1 = 1; writeAddr1 = 5'd2; writeData1 = 64'h5555;
    tick();
    readEn0 = 1; readAddr0 = 5'd1; expect0("dual_diff_r1", 64'hAAAA);
    readEn1 = 1; readAddr1 = 5'd2; expect1("dual_diff_r2", 64'h5555);
    tick();

    // Read-during-write returns old value
    writeEn0 = 1; writeAddr0 = 5'd3; writeData0 = 64'h10;
    tick();
    writeEn1 = 1; writeAddr1 = 5'd3; writeData1 = 64'h20;
    readEn0 = 1;  readAddr0 = 5'd3; expect0("rdw_old", 64'h10);
    tick();
    readEn0 = 1; readAddr0 = 5'd3; expect0("rdw_new", 64'h20);
    tick();

    // Hold with readEn0 low while r3 is rewritten
    writeEn0 = 1; writeAddr0 = 5'd3; writeData0 = 64'h30;
    readAddr0 = 5'd3;
    tick();
    check("hold_rd0", readData0, 64'h20);
    readEn1 = 1; readAddr1 = 5'd3; expect1("hold_r3_new", 64'h30);
    tick();
    check("hold_rd0_again", readData0, 64'h20);

    // Disabled write ports leave storage untouched
    writeAddr0 = 5'd5; writeData0 = 64'hFFFF_FFFF_FFFF_FFFF;
    writeAddr1 = 5'd5; writeData1 = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    readEn0 = 1; readAddr0 = 5'd5; expect0("nowr_r5", 64'h0123456789ABCDEF);
    tick();

    // r0 is an ordinary register
    writeEn1 = 1; writeAddr1 = 5'd0; writeData1 = 64'hC0FFEE00_12345678;
    tick();
    readEn1 = 1; readAddr1 = 5'd0; expect1("r0_writable", 64'hC0FFEE00_12345678);
    readEn0 = 1; readAddr0 = 5'd2; expect0("r2_kept", 64'h5555);
    tick();

    // Async reset between edges clears outputs immediately
    readEn0 = 1; readAddr0 = 5'd5; expect0("pre_arst_r5", 64'h0123456789ABCDEF);
    readEn1 = 1; readAddr1 = 5'd1; expect1("pre_arst_r1", 64'hAAAA);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_rd0", readData0, '0);
    check("arst_rd1", readData1, '0);
    // Reset held across an edge with writes and reads requested
    writeEn0 = 1; writeAddr0 = 5'd9; writeData0 = 64'h99;
    writeEn1 = 1; writeAddr1 = 5'd10; writeData1 = 64'hAA;
    readEn0 = 1; readAddr0 = 5'd5;
    @(posedge clk);
    #1;
    check("arst_edge_rd0", readData0, '0);
    idle();
    reset = 1'b0;

    for (int i = 0; i < GPR_COUNT; i++) begin
      readEn0 = 1; readAddr0 = gpr_addr_t'(i);
      readEn1 = 1; readAddr1 = gpr_addr_t'(GPR_COUNT - 1 - i);
      expect0($sformatf("post_arst_p0_r%0d", i), '0);
      expect1($sformatf("post_arst_p1_r%0d", GPR_COUNT - 1 - i), '0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
